// File: rtl/regfile_mp_scoreboard_if.sv
// Bundle between decode/writeback (master) and the register file (slave):
// read ports, write ports and the reservation port of the busy-bit scoreboard.
interface regfile_mp_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int IDXW = $clog2(NREGS);

    logic [NREAD*IDXW-1:0]  rs_index;
    logic [NREAD*XLEN-1:0]  rs_data;
    logic [NREAD-1:0]       rs_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*IDXW-1:0] wr_index;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [IDXW-1:0]        rsv_index;
    logic                   rsv_ok;

    // rsv_ok is a same-cycle accept: a request is taken only when rsv_en && rsv_ok.
    modport master (
        output rs_index, wr_en, wr_index, wr_data, rsv_en, rsv_index,
        input  rs_data, rs_busy, rsv_ok
    );

    modport slave (
        input  rs_index, wr_en, wr_index, wr_data, rsv_en, rsv_index,
        output rs_data, rs_busy, rsv_ok
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port RV32 integer register file with optional write-to-read bypass and
// a per-register busy scoreboard for pending multi-cycle results.
module regfile_mp_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_mp_scoreboard_if.slave  bus
);
    localparam int IDXW = $clog2(NREGS);

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      wr_hit;
    logic                  rsv_ok;
    logic [NREAD*XLEN-1:0] rs_data_c;
    logic [NREAD-1:0]      rs_busy_c;

    // One bit per register: some enabled write port targets it this cycle.
    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (bus.wr_en[w]) wr_hit[bus.wr_index[w*IDXW +: IDXW]] = 1'b1;
        end
    end

    // A busy register may be re-reserved in the cycle its writeback lands.
    always_comb begin
        rsv_ok = bus.rsv_en && !rst &&
                 ((bus.rsv_index == '0) || !busy[bus.rsv_index] || wr_hit[bus.rsv_index]);
    end

    always_comb begin
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] data;
        rs_data_c = '0;
        rs_busy_c = '0;
        idx       = '0;
        data      = '0;
        for (int p = 0; p < NREAD; p++) begin
            idx  = bus.rs_index[p*IDXW +: IDXW];
            data = regs[idx];
            if (BYPASS != 0) begin
                // Ascending scan so the highest-numbered write port wins.
                for (int w = 0; w < NWRITE; w++) begin
                    if (bus.wr_en[w] && bus.wr_index[w*IDXW +: IDXW] == idx)
                        data = bus.wr_data[w*XLEN +: XLEN];
                end
            end
            if (!rst && idx != '0) begin
                rs_data_c[p*XLEN +: XLEN] = data;
                rs_busy_c[p] = busy[idx] && !((BYPASS != 0) && wr_hit[idx]);
            end
        end
    end

    assign bus.rs_data = rs_data_c;
    assign bus.rs_busy = rs_busy_c;
    assign bus.rsv_ok  = rsv_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            // Later iterations override earlier ones: highest port wins on conflict.
            for (int w = 0; w < NWRITE; w++) begin
                if (bus.wr_en[w] && bus.wr_index[w*IDXW +: IDXW] != '0)
                    regs[bus.wr_index[w*IDXW +: IDXW]] <= bus.wr_data[w*XLEN +: XLEN];
            end
            // A new reservation outranks a writeback clearing the same register.
            for (int r = 1; r < NREGS; r++) begin
                if (rsv_ok && bus.rsv_index == IDXW'(r)) busy[r] <= 1'b1;
                else if (wr_hit[r])                      busy[r] <= 1'b0;
            end
        end
    end

`ifdef __DUMP_STATE__
    task automatic set_registers(input logic [NREGS*XLEN-1:0] values);
        for (int r = 1; r < NREGS; r++) regs[r] = values[r*XLEN +: XLEN];
        busy = '0;
    endtask

    final begin
        for (int r = 0; r < NREGS; r++)
            $display("x%0d = %h busy=%0d", r, regs[r], busy[r]);
    end
`endif
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_mp_scoreboard;
    localparam int XLEN = 32;
    localparam int IDXW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*IDXW-1:0] rs_index  = '0;
    logic [1:0]        wr_en     = '0;
    logic [2*IDXW-1:0] wr_index  = '0;
    logic [2*XLEN-1:0] wr_data   = '0;
    logic              rsv_en    = 1'b0;
    logic [IDXW-1:0]   rsv_index = '0;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_mp_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus1 ();
    regfile_mp_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus0 ();

    assign bus1.rs_index = rs_index;  assign bus0.rs_index = rs_index;
    assign bus1.wr_en = wr_en;        assign bus0.wr_en = wr_en;
    assign bus1.wr_index = wr_index;  assign bus0.wr_index = wr_index;
    assign bus1.wr_data = wr_data;    assign bus0.wr_data = wr_data;
    assign bus1.rsv_en = rsv_en;      assign bus0.rsv_en = rsv_en;
    assign bus1.rsv_index = rsv_index; assign bus0.rsv_index = rsv_index;

    regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1))
        dut_byp (.clk(clk), .rst(rst), .bus(bus1.slave));
    regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0))
        dut_nob (.clk(clk), .rst(rst), .bus(bus0.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_en = '0; wr_index = '0; wr_data = '0; rsv_en = 1'b0; rsv_index = '0;
    endtask

    task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
        rs_index = {p1, p0};
    endtask

    task automatic wr(input int port, input logic [4:0] idx, input logic [31:0] data);
        wr_en[port] = 1'b1;
        wr_index[port*IDXW +: IDXW] = idx;
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    function automatic logic [31:0] d1(input int p);
        return bus1.rs_data[p*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] d0(input int p);
        return bus0.rs_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        // Reset with a write and reservation presented: nothing may leak through.
        clr(); rd(5, 5); wr(0, 5, 32'h12345678); rsv_en = 1'b1; rsv_index = 5'd3;
        tick(); tick();
        #2;
        chk("rst_data_byp_p0", d1(0), 32'h0);
        chk("rst_data_byp_p1", d1(1), 32'h0);
        chk("rst_data_nob_p0", d0(0), 32'h0);
        chk("rst_busy_byp", {30'b0, bus1.rs_busy}, 32'h0);
        chk("rst_rsv_ok", {31'b0, bus1.rsv_ok}, 32'h0);
        tick(); rst = 1'b0; clr();
        #2;
        chk("post_rst_x5_byp", d1(0), 32'h0);
        chk("post_rst_x5_nob", d0(0), 32'h0);

        // Bypass: x7 old value 0x11111111, then same-cycle write of 0xDEADBEEF.
        wr(0, 7, 32'h11111111); tick(); clr();
        rd(0, 7); wr(0, 7, 32'hDEADBEEF);
        #2;
        chk("bypass_byp_p1", d1(1), 32'hDEADBEEF);
        chk("bypass_nob_p1", d0(1), 32'h11111111);
        chk("bypass_p0_x0", d1(0), 32'h0);
        tick(); clr();
        #2;
        chk("after_wr_nob_p1", d0(1), 32'hDEADBEEF);
        chk("after_wr_byp_p1", d1(1), 32'hDEADBEEF);

        // Write conflict on x3: port 1 must win, both in bypass and in storage.
        rd(3, 7); wr(0, 3, 32'h1); wr(1, 3, 32'h2);
        #2;
        chk("conflict_bypass", d1(0), 32'h2);
        tick(); clr();
        #2;
        chk("conflict_byp_x3", d1(0), 32'h2);
        chk("conflict_nob_x3", d0(0), 32'h2);

        // Scoreboard: reserve x10, then a repeat request must be rejected.
        rd(10, 3); rsv_en = 1'b1; rsv_index = 5'd10;
        #2;
        chk("rsv_x10_ok", {31'b0, bus1.rsv_ok}, 32'h1);
        chk("rsv_x10_busy_before", {31'b0, bus1.rs_busy[0]}, 32'h0);
        tick();
        #2;
        chk("rsv_x10_busy_byp", {31'b0, bus1.rs_busy[0]}, 32'h1);
        chk("rsv_x10_busy_nob", {31'b0, bus0.rs_busy[0]}, 32'h1);
        chk("rsv_x10_again_rej", {31'b0, bus1.rsv_ok}, 32'h0);
        chk("x3_not_busy", {31'b0, bus1.rs_busy[1]}, 32'h0);
        tick(); clr();

        // Writeback of x10 = 0x55 through port 1.
        wr(1, 10, 32'h55);
        #2;
        chk("wb_busy_byp_hidden", {31'b0, bus1.rs_busy[0]}, 32'h0);
        chk("wb_busy_nob_stored", {31'b0, bus0.rs_busy[0]}, 32'h1);
        chk("wb_data_byp", d1(0), 32'h55);
        tick(); clr();
        #2;
        chk("wb_busy_cleared", {31'b0, bus0.rs_busy[0]}, 32'h0);
        chk("wb_data_nob", d0(0), 32'h55);

        // Writeback and re-reserve of x10 in the same cycle: busy must stay set.
        rsv_en = 1'b1; rsv_index = 5'd10; tick(); clr();
        rsv_en = 1'b1; rsv_index = 5'd10;
        #2;
        chk("rerv_rej_no_wb", {31'b0, bus1.rsv_ok}, 32'h0);
        wr(0, 10, 32'h77);
        #1;
        chk("rerv_ok_with_wb", {31'b0, bus1.rsv_ok}, 32'h1);
        tick(); clr();
        #2;
        chk("rerv_data", d0(0), 32'h77);
        chk("rerv_busy_held", {31'b0, bus0.rs_busy[0]}, 32'h1);

        // x0: writes and reservation ignored, reservation still accepted.
        rd(0, 0); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF);
        rsv_en = 1'b1; rsv_index = 5'd0;
        #2;
        chk("x0_bypass_data", d1(0), 32'h0);
        chk("x0_rsv_ok", {31'b0, bus1.rsv_ok}, 32'h1);
        chk("x0_busy", {30'b0, bus1.rs_busy}, 32'h0);
        tick(); clr();
        #2;
        chk("x0_stored_p1", d1(1), 32'h0);
        chk("x0_busy_after", {30'b0, bus0.rs_busy}, 32'h0);

        // Asynchronous reset mid-operation: x3 and the x10 reservation are lost.
        rd(3, 10);
        #2;
        chk("pre_rst_x3", d0(0), 32'h2);
        rst = 1'b1;
        #1;
        chk("async_rst_data", d1(0), 32'h0);
        rst = 1'b0;
        tick();
        #2;
        chk("post_rst2_x3", d0(0), 32'h0);
        chk("post_rst2_busy_x10", {31'b0, bus0.rs_busy[1]}, 32'h0);
        rsv_en = 1'b1; rsv_index = 5'd10;
        #1;
        chk("post_rst2_rsv_ok", {31'b0, bus1.rsv_ok}, 32'h1);
        tick(); clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
